// File: rtl/row_clear_engine.sv
// row_clear_engine: removes every full row from a captured board, compacting the
// remaining rows downward one row per clock, then reports the result and the count.
module row_clear_engine #(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [COLS*ROWS-1:0] blocks_exist_in,
    output logic [COLS*ROWS-1:0] blocks_exist_clear,
    output logic                 done_clear,
    output logic [CNT_W-1:0]     rows_cleared,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
    state_t               state;
    logic [COLS*ROWS-1:0] src, dst;
    logic [CNT_W-1:0]     rd_row, wr_row, count;
    logic [COLS-1:0]      row;
    assign row = src[int'(rd_row)*COLS +: COLS];
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            src                <= '0;
            dst                <= '0;
            rd_row             <= '0;
            wr_row             <= '0;
            count              <= '0;
            blocks_exist_clear <= '0;
            rows_cleared       <= '0;
            done_clear         <= 1'b0;
            busy               <= 1'b0;
        end else begin
            done_clear <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        src    <= blocks_exist_in;
                        dst    <= '0;
                        rd_row <= CNT_W'(ROWS-1);
                        wr_row <= CNT_W'(ROWS-1);
                        count  <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    // full rows are skipped; wr_row only wraps after its final write
                    if (&row) count <= count + CNT_W'(1);
                    else begin
                        dst[int'(wr_row)*COLS +: COLS] <= row;
                        wr_row                         <= wr_row - CNT_W'(1);
                    end
                    rd_row <= rd_row - CNT_W'(1);
                    if (rd_row == '0) state <= FINISH;
                end
                FINISH: begin
                    blocks_exist_clear <= dst;
                    rows_cleared       <= count;
                    done_clear         <= 1'b1;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_row_clear_engine.sv
// tb_row_clear_engine: random and directed boards; expected results queued at issue
// time and compared by an independent monitor whenever done_clear fires.
module tb_row_clear_engine;
    localparam int COLS = 10, ROWS = 20, CNT_W = 5, N = COLS*ROWS;
    logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [N-1:0]     din = '0;
    logic [N-1:0]     blocks_exist_clear;
    logic             done_clear, busy;
    logic [CNT_W-1:0] rows_cleared;
    typedef struct {logic [N-1:0] b; int c;} exp_t;
    exp_t         q[$];
    exp_t         pe;
    logic [N-1:0] last_b = '0;
    int           last_c = 0;
    int           compared = 0, mismatched = 0;

    row_clear_engine #(.COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .blocks_exist_in(din),
        .blocks_exist_clear(blocks_exist_clear), .done_clear(done_clear),
        .rows_cleared(rows_cleared), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: keep non-full rows in bottom-up order and stack them from the bottom.
    function automatic void model(input logic [N-1:0] b, output logic [N-1:0] r, output int c);
        logic [COLS-1:0] kept[$];
        r = '0;
        c = 0;
        for (int i = ROWS-1; i >= 0; i--)
            if (&b[i*COLS +: COLS]) c++;
            else kept.push_back(b[i*COLS +: COLS]);
        foreach (kept[k]) r[(ROWS-1-k)*COLS +: COLS] = kept[k];
    endfunction

    function automatic logic [N-1:0] rand_board();
        logic [N-1:0] b = '0;
        for (int i = 0; i < ROWS; i++)
            case ($urandom_range(0, 2))
                0: b[i*COLS +: COLS] = '1;
                1: b[i*COLS +: COLS] = COLS'($urandom);
                default: b[i*COLS +: COLS] = '0;
            endcase
        return b;
    endfunction

    always @(negedge clk)
        if (done_clear) begin
            if (q.size() == 0) check("unexpected_done", N'(1), N'(0));
            else begin
                pe = q.pop_front();
                check("board", blocks_exist_clear, pe.b);
                check("rows_cleared", N'(rows_cleared), N'(pe.c));
                last_b = pe.b;
                last_c = pe.c;
            end
        end

    // g: 0 plain, 1 extra start with a new board mid-scan, 2 start on the FINISH edge
    task automatic run_op(input logic [N-1:0] b, input int g);
        logic [N-1:0] r;
        int           c, n, bn;
        exp_t         e;
        model(b, r, c);
        e.b = r;
        e.c = c;
        @(negedge clk);
        start = 1'b1;
        din   = b;
        q.push_back(e);
        n  = 0;
        bn = 0;
        do begin
            @(negedge clk);
            n++;
            bn += int'(busy);
            start = 1'b0;
            if (n == 1) din = ~b;
            if (g == 1 && n == 5) begin start = 1'b1; din = rand_board(); end
            if (g == 2 && n == ROWS+1) start = 1'b1;
            if (n == 10) begin
                check("hold_board", blocks_exist_clear, last_b);
                check("hold_rows", N'(rows_cleared), N'(last_c));
            end
        end while (!done_clear && n < 100);
        check("latency", N'(n-1), N'(ROWS+1));
        check("busy_span", N'(bn), N'(n));
        @(negedge clk);
        check("busy_after", N'(busy), N'(0));
        check("done_after", N'(done_clear), N'(0));
    endtask

    initial begin
        logic [N-1:0] b;
        int           dn;
        repeat (3) @(negedge clk);
        check("rst_board", blocks_exist_clear, '0);
        check("rst_rows", N'(rows_cleared), N'(0));
        check("rst_done", N'(done_clear), N'(0));
        check("rst_busy", N'(busy), N'(0));
        rst = 1'b0;
        run_op('0, 0);
        b = '0;
        b[19*COLS +: COLS] = '1;
        b[18*COLS +: COLS] = 10'b0000000011;
        run_op(b, 0);
        b = '0;
        b[19*COLS +: COLS] = '1;
        b[18*COLS +: COLS] = 10'h155;
        b[17*COLS +: COLS] = '1;
        b[16*COLS +: COLS] = 10'h0AA;
        run_op(b, 0);
        run_op('1, 0);
        run_op('0, 0);
        // abort mid-operation, with start coinciding with the reset edge
        @(negedge clk);
        start = 1'b1;
        din   = rand_board();
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        last_b = '0;
        last_c = 0;
        check("abort_busy", N'(busy), N'(0));
        check("abort_board", blocks_exist_clear, '0);
        check("abort_rows", N'(rows_cleared), N'(0));
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            dn += int'(done_clear);
        end
        check("abort_no_done", N'(dn), N'(0));
        run_op(rand_board(), 0);
        run_op(rand_board(), 1);
        run_op(rand_board(), 2);
        for (int i = 0; i < 15; i++) run_op(rand_board(), i % 3);
        repeat (5) @(negedge clk);
        check("queue_drained", N'(q.size()), N'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
